axi_write_arbiter: RTL

Write-path arbiter for one slave port of the AXI crossbar mux stage. It shares a single downstream AW channel between MASTER_NUM upstream requesters using a round-robin policy, and records the order in which AW bursts are granted. It uses that order to route each requester's W beats to the slave in matching order, switching at WLAST. The arbiter is control only: it produces one-hot select vectors and handshake signals, and the enclosing mux steers the payload (addr, id, data, strb).

---
 rtl/axi_common_pkg.sv | 39 +++
 rtl/axi_rr_arbiter.sv | 67 ++++++
 rtl/axi_write_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/axi_common_pkg.sv
// Shared helpers for the AXI crossbar arbiters: round-robin pick and one-hot decode.
// Functions work on a fixed maximum width; callers cast to their own MASTER_NUM.
package axi_common;

  localparam int unsigned MAX_MASTERS = 32;

  // First asserted valid bit at or after ptr, modulo n; returns 1 when something was found.
  function automatic logic rr_pick(input  logic [MAX_MASTERS-1:0] valid,
                                   input  int unsigned            ptr,
                                   input  int unsigned            n,
                                   output int unsigned            idx);
    logic        found;
    int unsigned cand;
    found = 1'b0;
    idx   = 32'd0;
    for (int unsigned k = 32'd0; k < MAX_MASTERS; k++) begin
      cand = ptr + k;
      if (cand >= n) begin
        cand = cand - n;
      end else begin
        cand = cand;
      end
      if ((k < n) && !found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
    return found;
  endfunction

  function automatic logic [MAX_MASTERS-1:0] onehot(input int unsigned idx);
    logic [MAX_MASTERS-1:0] one;
    one = {{(MAX_MASTERS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter with grant lock: holds the granted requester while the
// downstream stalls, and advances the priority pointer past each accepted grant.
module axi_rr_arbiter
  import axi_common::*;
#(
  parameter int unsigned MASTER_NUM = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [MASTER_NUM-1:0]         req_i,
  input  logic                          advance_i,
  input  logic                          hold_i,
  output logic [$clog2(MASTER_NUM)-1:0] grant_o,
  output logic                          found_o
);

  localparam int unsigned IDX_W = $clog2(MASTER_NUM);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             pick_found_s;
  int unsigned      pick_idx_s;

  // Grant selection: a locked grant overrides the round-robin scan.
  always_comb begin
    pick_idx_s   = 32'd0;
    pick_found_s = rr_pick(MAX_MASTERS'(req_i), 32'(ptr_q), MASTER_NUM, pick_idx_s);
    if (lock_q) begin
      grant_o = lock_idx_q;
      found_o = 1'b1;
    end else begin
      grant_o = IDX_W'(pick_idx_s);
      found_o = pick_found_s;
    end
  end

  // Next-state for pointer and lock.
  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (advance_i) begin
      ptr_d  = (grant_o == IDX_W'(MASTER_NUM-1)) ? {IDX_W{1'b0}} : grant_o + IDX_W'(1);
      lock_d = 1'b0;
    end else if (hold_i) begin
      lock_d     = 1'b1;
      lock_idx_d = grant_o;
    end else begin
      lock_d = lock_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q      <= {IDX_W{1'b0}};
      lock_q     <= 1'b0;
      lock_idx_q <= {IDX_W{1'b0}};
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// AW round-robin arbiter plus an order FIFO of granted requesters that steers
// W beats to the slave in AW grant order, advancing at WLAST.
module axi_write_arbiter
  import axi_common::*;
#(
  parameter int unsigned MASTER_NUM = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [MASTER_NUM-1:0] aw_valid,
  output logic [MASTER_NUM-1:0] aw_ready,
  output logic [MASTER_NUM-1:0] aw_sel,
  output logic                  aw_valid_o,
  input  logic                  aw_ready_i,
  input  logic [MASTER_NUM-1:0] w_valid,
  input  logic [MASTER_NUM-1:0] w_last,
  output logic [MASTER_NUM-1:0] w_ready,
  output logic [MASTER_NUM-1:0] w_sel,
  output logic                  w_valid_o,
  input  logic                  w_ready_i
);

  localparam int unsigned IDX_W = $clog2(MASTER_NUM);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [IDX_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] grant_s;
  logic             found_s;
  logic             full_s;
  logic             nonempty_s;
  logic [IDX_W-1:0] head_s;
  logic             push_s;
  logic             pop_s;

  assign full_s     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign nonempty_s = (cnt_q != {CNT_W{1'b0}});
  assign head_s     = fifo_q[rd_ptr_q];
  assign push_s     = aw_valid_o & aw_ready_i;
  assign pop_s      = w_valid_o & w_ready_i & w_last[head_s];

  axi_rr_arbiter #(
    .MASTER_NUM(MASTER_NUM)
  ) u_rr (
    .clk      (clk),
    .rstn     (rstn),
    .req_i    (aw_valid),
    .advance_i(push_s),
    .hold_i   (aw_valid_o & ~aw_ready_i),
    .grant_o  (grant_s),
    .found_o  (found_s)
  );

  // Handshake outputs; full blocking deliberately ignores a same-cycle pop so
  // that w_ready_i never reaches the AW ready path.
  always_comb begin
    aw_sel     = {MASTER_NUM{1'b0}};
    aw_valid_o = 1'b0;
    aw_ready   = {MASTER_NUM{1'b0}};
    w_sel      = {MASTER_NUM{1'b0}};
    w_valid_o  = 1'b0;
    w_ready    = {MASTER_NUM{1'b0}};
    if (rstn && found_s && !full_s) begin
      aw_sel     = MASTER_NUM'(onehot(32'(grant_s)));
      aw_valid_o = aw_valid[grant_s];
      aw_ready   = aw_sel & {MASTER_NUM{aw_ready_i}};
    end else begin
      aw_valid_o = 1'b0;
    end
    if (rstn && nonempty_s) begin
      w_sel     = MASTER_NUM'(onehot(32'(head_s)));
      w_valid_o = w_valid[head_s];
      w_ready   = w_sel & {MASTER_NUM{w_ready_i}};
    end else begin
      w_valid_o = 1'b0;
    end
  end

  // Order FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Order FIFO storage and pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= {IDX_W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_s) begin
        fifo_q[wr_ptr_q] <= grant_s;
      end else begin
        fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
      end
    end
  end

endmodule
